// File: rtl/servo_sequencer_n.sv
// Purpose: N-channel servo position sequencer; one command at a time, per-command settle timer, done/err pulses.
// Latency: real move -> done after SETTLE_CYCLES+1 edges; same-position or invalid channel -> pulse one edge after accept.
// Backpressure: cmd_ready is high only in IDLE; cmd_ch/cmd_pos are sampled at the acceptance edge only.
module servo_sequencer_n #(
  parameter int N_CH          = 3,
  parameter int CH_W          = 2,
  parameter int POS_W         = 2,
  parameter int SETTLE_CYCLES = 25000000,
  parameter int TIMER_W       = 25,
  parameter logic [POS_W-1:0] RESET_POS = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [CH_W-1:0]        cmd_ch,
  input  logic [POS_W-1:0]       cmd_pos,
  input  logic                   abort,
  output logic [N_CH*POS_W-1:0]  pos,
  output logic [CH_W-1:0]        active_ch,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [2:0]             db_estado
);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    LOAD    = 3'b001,
    SETTLE  = 3'b010,
    DONE    = 3'b011,
    ERR     = 3'b100,
    ABORTED = 3'b101
  } state_t;

  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);

  state_t                  state;
  state_t                  state_d;
  logic [N_CH*POS_W-1:0]   pos_q;
  logic [CH_W-1:0]         active_ch_q;
  logic [POS_W-1:0]        load_pos;
  logic [TIMER_W-1:0]      counter;
  logic                    ch_valid;
  logic [POS_W-1:0]        cur_pos;
  logic                    start_move;

  // Decode the requested channel: range check plus its current position code.
  always_comb begin
    ch_valid = 1'b0;
    cur_pos  = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (cmd_ch == CH_W'(c)) begin
        ch_valid = 1'b1;
        cur_pos  = pos_q[c*POS_W +: POS_W];
      end
    end
  end

  // Next-state logic; abort outranks settle expiry, illegal codes fall back to IDLE.
  always_comb begin
    state_d = IDLE;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (!ch_valid)
            state_d = ERR;
          else if (cmd_pos == cur_pos)
            state_d = DONE;
          else
            state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD:    state_d = SETTLE;
      SETTLE: begin
        if (abort)
          state_d = ABORTED;
        else if (counter == SETTLE_LAST)
          state_d = DONE;
        else
          state_d = SETTLE;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      ABORTED: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == DONE) || (state == ABORTED);
    err       = (state == ERR)  || (state == ABORTED);
    case (state)
      IDLE, LOAD, SETTLE, DONE, ERR, ABORTED: db_estado = state;
      default:                                db_estado = 3'b111;
    endcase
  end

  assign start_move = (state == IDLE) && (state_d == LOAD);
  assign pos        = pos_q;
  assign active_ch  = active_ch_q;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_d;
  end

  // Capture the command at acceptance so later input changes cannot leak in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_ch_q <= '0;
      load_pos    <= '0;
    end else if (start_move) begin
      active_ch_q <= cmd_ch;
      load_pos    <= cmd_pos;
    end
  end

  // Position registers: only the active channel changes, and only at the LOAD edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_q <= {N_CH{RESET_POS}};
    end else if (state == LOAD) begin
      for (int c = 0; c < N_CH; c++) begin
        if (active_ch_q == CH_W'(c))
          pos_q[c*POS_W +: POS_W] <= load_pos;
      end
    end
  end

  // Settle counter: counts while staying in SETTLE, held at zero everywhere else.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      counter <= '0;
    else if ((state == SETTLE) && (state_d == SETTLE))
      counter <= counter + TIMER_W'(1);
    else
      counter <= '0;
  end

endmodule

// File: tb/tb_servo_sequencer_n.sv
// Bench for servo_sequencer_n with N_CH=3, SETTLE_CYCLES=4, POS_W=2.
// Expected done/err pulses are queued by stimulus and checked by an independent monitor.
module tb_servo_sequencer_n;

  localparam int S = 4;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_ch;
  logic [1:0] cmd_pos;
  logic       abort;
  logic [5:0] pos;
  logic [1:0] active_ch;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] db_estado;

  servo_sequencer_n #(
    .N_CH(3), .CH_W(2), .POS_W(2), .SETTLE_CYCLES(S), .TIMER_W(3), .RESET_POS(2'b00)
  ) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_pos(cmd_pos), .abort(abort), .pos(pos),
    .active_ch(active_ch), .busy(busy), .done(done), .err(err), .db_estado(db_estado)
  );

  typedef struct {
    int         cyc;
    logic       done;
    logic       err;
    logic [5:0] pos;
    logic [2:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done/err pulse must match the head of the expectation queue.
  always @(negedge clock) begin
    if (!reset && (done || err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, done, err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_done", {31'd0, done}, {31'd0, e.done});
        check("pulse_err", {31'd0, err}, {31'd0, e.err});
        check("pulse_pos", {26'd0, pos}, {26'd0, e.pos});
        check("pulse_state", {29'd0, db_estado}, {29'd0, e.st});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_exp(input int c, input logic d, input logic e, input logic [5:0] p, input logic [2:0] st);
    exp_t x;
    x.cyc = c; x.done = d; x.err = e; x.pos = p; x.st = st;
    exp_q.push_back(x);
  endtask

  // Issue one command; c returns the cycle count seen just before the acceptance edge.
  task automatic send(input logic [1:0] ch, input logic [1:0] p, input bit push, input int delay,
                      input logic d, input logic e, input logic [5:0] ep, input logic [2:0] st,
                      output int c);
    wait_ready();
    c = cyc;
    if (push) push_exp(c + delay, d, e, ep, st);
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_pos   = p;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_ch    = 2'b00;
    cmd_pos   = 2'b00;
  endtask

  task automatic wait_until(input int target);
    int n = 0;
    while (cyc < target && n < 100) begin
      @(negedge clock);
      n++;
    end
  endtask

  initial begin
    int c;
    int c2;
    reset = 1'b1; cmd_valid = 1'b0; cmd_ch = 2'b00; cmd_pos = 2'b00; abort = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_pos", {26'd0, pos}, 32'h00);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {29'd0, db_estado}, 32'd0);
    check("rst_active_ch", {30'd0, active_ch}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Reset in the middle of SETTLE: everything back to reset values, no pulse.
    send(2'd0, 2'b11, 1'b0, 0, 1'b0, 1'b0, 6'h00, 3'b000, c);
    wait_until(c + 3);
    check("pre_rst_settle", {29'd0, db_estado}, 32'b010);
    check("pre_rst_pos", {26'd0, pos}, 32'b000011);
    #2 reset = 1'b1;
    #1;
    check("midrst_pos", {26'd0, pos}, 32'h00);
    check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_state", {29'd0, db_estado}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    wait_until(c + 9);

    // Normal move: ch1 -> 10.
    send(2'd1, 2'b10, 1'b1, S + 2, 1'b1, 1'b0, 6'b001000, 3'b011, c);
    check("move_load_state", {29'd0, db_estado}, 32'b001);
    check("move_load_pos", {26'd0, pos}, 32'h00);
    check("move_active_ch", {30'd0, active_ch}, 32'd1);
    @(negedge clock);
    check("move_settle_state", {29'd0, db_estado}, 32'b010);
    check("move_pos", {26'd0, pos}, 32'b001000);
    wait_until(c + S + 1);
    check("move_busy_before_done", {31'd0, cmd_ready}, 32'd0);
    wait_until(c + S + 2);
    check("move_not_ready_in_done", {31'd0, cmd_ready}, 32'd0);
    @(negedge clock);
    check("move_ready_back", {31'd0, cmd_ready}, 32'd1);

    // Same position: straight to DONE, no LOAD/SETTLE.
    send(2'd1, 2'b10, 1'b1, 1, 1'b1, 1'b0, 6'b001000, 3'b011, c);
    check("same_state_done", {29'd0, db_estado}, 32'b011);
    @(negedge clock);
    check("same_idle", {29'd0, db_estado}, 32'b000);
    check("same_pos", {26'd0, pos}, 32'b001000);

    // Invalid channel: err only, pos untouched.
    send(2'd3, 2'b11, 1'b1, 1, 1'b0, 1'b1, 6'b001000, 3'b100, c);
    @(negedge clock);
    check("inv_ready_back", {31'd0, cmd_ready}, 32'd1);
    check("inv_idle", {29'd0, db_estado}, 32'b000);
    check("inv_pos", {26'd0, pos}, 32'b001000);

    // Abort on the second SETTLE cycle: ch0 -> 01 kept, done+err together.
    send(2'd0, 2'b01, 1'b1, 4, 1'b1, 1'b1, 6'b001001, 3'b101, c);
    @(negedge clock);
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    @(negedge clock);
    check("abort_idle", {29'd0, db_estado}, 32'b000);
    check("abort_pos", {26'd0, pos}, 32'b001001);

    // Back-to-back with cmd_valid held: ch0 -> 11, then ch2 -> 01.
    wait_ready();
    c = cyc;
    push_exp(c + S + 2, 1'b1, 1'b0, 6'b001011, 3'b011);
    c2 = c + S + 3;
    push_exp(c2 + S + 2, 1'b1, 1'b0, 6'b011011, 3'b011);
    cmd_valid = 1'b1; cmd_ch = 2'd0; cmd_pos = 2'b11;
    @(negedge clock);
    cmd_ch = 2'd2; cmd_pos = 2'b01;
    wait_until(c2 + 1);
    check("b2b_second_load", {29'd0, db_estado}, 32'b001);
    check("b2b_active_ch", {30'd0, active_ch}, 32'd2);
    cmd_valid = 1'b0;
    wait_until(c2 + S + 4);
    check("b2b_pos", {26'd0, pos}, 32'b011011);

    check("pending_pulses", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
